// File: rtl/pht_update_sched_pkg.sv
// Shared predictor types for the choice-counter table (CPHT) write scheduler.
package pht_update_sched_pkg;

    localparam int PHT_IDX_W     = 11;
    localparam int PHT_DATA_W    = 2;
    localparam int PHT_TBL_DEPTH = 2048;
    localparam int PHT_Q_DEPTH   = 4;

    typedef logic [PHT_IDX_W-1:0]  PhtIdx_t;
    typedef logic [PHT_DATA_W-1:0] TwoBitState;

    localparam TwoBitState PHT_INIT_VAL = 2'b01;

    typedef struct packed {
        logic       valid;
        PhtIdx_t    idx;
        TwoBitState data;
    } PhtUpdReq_S;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pht_upd_queue.sv
// Coalescing CAM-style update queue: circular storage addressed by head pointer and
// count, index match overwrites in place, newest-match forwarding lookup.
module pht_upd_queue
    import pht_update_sched_pkg::*;
#(
    parameter  int Q_DEPTH = PHT_Q_DEPTH,
    localparam int PTR_W   = $clog2(Q_DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  PhtUpdReq_S       enq0,
    input  PhtUpdReq_S       enq1,
    input  logic             deq,
    input  PhtIdx_t          rd_idx,
    output logic [CNT_W-1:0] count,
    output PhtIdx_t          head_idx,
    output TwoBitState       head_data,
    output logic             fwd_hit,
    output TwoBitState       fwd_data,
    output logic [1:0]       coalesce_cnt
);

    PhtIdx_t    q_idx    [Q_DEPTH];
    TwoBitState q_data   [Q_DEPTH];
    PhtIdx_t    q_idx_n  [Q_DEPTH];
    TwoBitState q_data_n [Q_DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   slot0, slot1;
    logic [Q_DEPTH-1:0] stay, match0, match1;
    logic               hit0, hit1, same, alloc0, alloc1;

    // NOTE: combinational blocks use blocking '=' so later statements see earlier
    // results and every output gets a default first (no latches); flops use '<='.
    always_comb begin
        stay = '0;
        for (int k = 0; k < Q_DEPTH; k++) begin
            if (CNT_W'(k) < count) stay[head + PTR_W'(k)] = 1'b1;
        end
        // The head leaving this cycle cannot absorb a coalesce.
        if (deq) stay[head] = 1'b0;

        for (int s = 0; s < Q_DEPTH; s++) begin
            match0[s] = stay[s] && enq0.valid && (q_idx[s] == enq0.idx);
            match1[s] = stay[s] && enq1.valid && (q_idx[s] == enq1.idx);
        end
        hit0   = |match0;
        hit1   = |match1;
        same   = enq0.valid && enq1.valid && (enq0.idx == enq1.idx);
        alloc0 = enq0.valid && !hit0;
        alloc1 = enq1.valid && !same && !hit1;
        slot0  = head + count[PTR_W-1:0];
        slot1  = slot0 + PTR_W'(alloc0);

        // Source 0 is applied first so a same-index source 1 overwrites its data.
        q_idx_n  = q_idx;
        q_data_n = q_data;
        for (int s = 0; s < Q_DEPTH; s++) begin
            if (match0[s]) q_data_n[s] = enq0.data;
        end
        if (alloc0) begin
            q_idx_n[slot0]  = enq0.idx;
            q_data_n[slot0] = enq0.data;
        end
        for (int s = 0; s < Q_DEPTH; s++) begin
            if (match1[s]) q_data_n[s] = enq1.data;
        end
        if (same && alloc0) q_data_n[slot0] = enq1.data;
        if (alloc1) begin
            q_idx_n[slot1]  = enq1.idx;
            q_data_n[slot1] = enq1.data;
        end

        coalesce_cnt = {1'b0, hit0} + {1'b0, enq1.valid && (same || hit1)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            count <= count + CNT_W'(alloc0) + CNT_W'(alloc1) - CNT_W'(deq);
        end
    end

    // NOTE: entry storage is not reset; an entry is only meaningful while it lies
    // inside the head/count window, which reset empties.
    always_ff @(posedge clk) begin
        q_idx  <= q_idx_n;
        q_data <= q_data_n;
    end

    assign head_idx  = q_idx[head];
    assign head_data = q_data[head];

    // Walk oldest to newest so the newest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < Q_DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (q_idx[head + PTR_W'(k)] == rd_idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[head + PTR_W'(k)];
            end
        end
    end

endmodule

// File: rtl/pht_update_sched.sv
// CPHT write-port scheduler: init sweep, then two-source update arbitration through a
// coalescing queue with read forwarding. Optional stats counters: PHT_UPD_STATS_EN.
module pht_update_sched
    import pht_update_sched_pkg::*;
#(
    parameter  int         TBL_DEPTH = PHT_TBL_DEPTH,
    parameter  int         Q_DEPTH   = PHT_Q_DEPTH,
    parameter  TwoBitState INIT_VAL  = PHT_INIT_VAL,
    localparam int         IDX_W     = PHT_IDX_W,
    localparam int         DATA_W    = PHT_DATA_W,
    localparam int         CNT_W     = $clog2(Q_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up0_valid,
    output logic              up0_ready,
    input  logic [IDX_W-1:0]  up0_idx,
    input  logic [DATA_W-1:0] up0_data,
    input  logic              up1_valid,
    output logic              up1_ready,
    input  logic [IDX_W-1:0]  up1_idx,
    input  logic [DATA_W-1:0] up1_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              init_done,
    output logic [31:0]       stat_coalesce,
    output logic [31:0]       stat_stall
);

    sched_state_e      state, state_n;
    logic [IDX_W-1:0]  ptr, ptr_n, wr_idx_n;
    logic [DATA_W-1:0] wr_data_n;
    logic              wr_en_n, init_done_n, ready, deq;

    PhtUpdReq_S        enq0, enq1;
    logic [CNT_W-1:0]  q_count;
    PhtIdx_t           q_head_idx;
    TwoBitState        q_head_data, q_fwd_data;
    logic              q_fwd_hit;
    logic [1:0]        q_coal;

    // Two free slots guarantee both sources can allocate in the same cycle.
    assign ready     = (state == ST_RUN) && (q_count <= CNT_W'(Q_DEPTH - 2));
    assign up0_ready = ready;
    assign up1_ready = ready;
    assign enq0      = '{valid: up0_valid && ready, idx: up0_idx, data: up0_data};
    assign enq1      = '{valid: up1_valid && ready, idx: up1_idx, data: up1_data};
    assign deq       = (state == ST_RUN) && (q_count != '0);

    pht_upd_queue #(.Q_DEPTH(Q_DEPTH)) u_queue (
        .clk          (clk),
        .reset        (reset),
        .enq0         (enq0),
        .enq1         (enq1),
        .deq          (deq),
        .rd_idx       (rd_idx),
        .count        (q_count),
        .head_idx     (q_head_idx),
        .head_data    (q_head_data),
        .fwd_hit      (q_fwd_hit),
        .fwd_data     (q_fwd_data),
        .coalesce_cnt (q_coal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            ptr       <= '0;
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            wr_en     <= wr_en_n;
            wr_idx    <= wr_idx_n;
            wr_data   <= wr_data_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        init_done_n = init_done;
        wr_en_n     = 1'b0;
        wr_idx_n    = q_head_idx;
        wr_data_n   = q_head_data;
        case (state)
            ST_INIT: begin
                wr_en_n   = 1'b1;
                wr_idx_n  = ptr;
                wr_data_n = INIT_VAL;
                ptr_n     = ptr + IDX_W'(1);
                if (ptr == IDX_W'(TBL_DEPTH - 1)) begin
                    state_n     = ST_RUN;
                    init_done_n = 1'b1;
                end
            end
            ST_RUN:  wr_en_n = deq;
            default: state_n = ST_INIT;
        endcase
    end

    // Queued data is newer than the write already on the port.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (reset) begin
            fwd_hit = 1'b0;
        end else if (state == ST_INIT) begin
            fwd_hit  = 1'b1;
            fwd_data = INIT_VAL;
        end else if (q_fwd_hit) begin
            fwd_hit  = 1'b1;
            fwd_data = q_fwd_data;
        end else if (wr_en && (wr_idx == rd_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = wr_data;
        end
    end

`ifdef PHT_UPD_STATS_EN
    logic [31:0] coal_q, stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            coal_q  <= '0;
            stall_q <= '0;
        end else begin
            coal_q <= coal_q + 32'(q_coal);
            if ((state == ST_RUN) && (up0_valid || up1_valid) && !ready)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_coalesce = coal_q;
    assign stat_stall    = stall_q;
`else
    logic unused_coal;
    assign unused_coal   = ^q_coal;
    assign stat_coalesce = '0;
    assign stat_stall    = '0;
`endif

endmodule

// File: tb/tb_pht_update_sched.sv
// Bench for pht_update_sched: directed steps plus randomized traffic checked against a
// queue-based reference model of the update/write/forward behaviour.
module tb_pht_update_sched;
    import pht_update_sched_pkg::*;

    localparam int QD = PHT_Q_DEPTH;
    localparam int TD = PHT_TBL_DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        up0_valid, up1_valid, up0_ready, up1_ready;
    logic [10:0] up0_idx, up1_idx, wr_idx, rd_idx;
    logic [1:0]  up0_data, up1_data, wr_data, fwd_data;
    logic        wr_en, fwd_hit, init_done;
    logic [31:0] stat_coalesce, stat_stall;

    always #5 clk = ~clk;

    pht_update_sched dut (
        .clk           (clk),
        .reset         (reset),
        .up0_valid     (up0_valid),
        .up0_ready     (up0_ready),
        .up0_idx       (up0_idx),
        .up0_data      (up0_data),
        .up1_valid     (up1_valid),
        .up1_ready     (up1_ready),
        .up1_idx       (up1_idx),
        .up1_data      (up1_data),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .rd_idx        (rd_idx),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data),
        .init_done     (init_done),
        .stat_coalesce (stat_coalesce),
        .stat_stall    (stat_stall)
    );

    typedef struct {
        logic [10:0] idx;
        logic [1:0]  data;
    } ent_t;

    // Reference model: pending updates in arrival order, the expected write port, stats.
    ent_t        mq[$];
    ent_t        wlog[$];
    logic        m_wr_en;
    logic [10:0] m_wr_idx;
    logic [1:0]  m_wr_data;
    int unsigned m_coal, m_stall;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        wlog.delete();
        m_wr_en   = 1'b1;
        m_wr_idx  = 11'(TD - 1);
        m_wr_data = 2'b01;
        m_coal    = 0;
        m_stall   = 0;
    endtask

    task automatic model_apply(input logic [10:0] idx, input logic [1:0] data);
        int f = -1;
        foreach (mq[i]) if (mq[i].idx == idx) f = i;
        if (f >= 0) begin
            mq[f].data = data;
            m_coal++;
        end else begin
            mq.push_back('{idx: idx, data: data});
        end
    endtask

    // One clock edge as seen by the model: retire the oldest pending update, then accept.
    task automatic model_step();
        bit rdy = (mq.size() <= QD - 2);
        ent_t e;
        if ((up0_valid || up1_valid) && !rdy) m_stall++;
        if (mq.size() > 0) begin
            e         = mq.pop_front();
            m_wr_en   = 1'b1;
            m_wr_idx  = e.idx;
            m_wr_data = e.data;
        end else begin
            m_wr_en = 1'b0;
        end
        if (rdy && up0_valid) model_apply(up0_idx, up0_data);
        if (rdy && up1_valid) model_apply(up1_idx, up1_data);
    endtask

    task automatic compare_all(input string tag);
        logic       e_hit  = 1'b0;
        logic [1:0] e_data = 2'b00;
        bit         e_rdy  = (mq.size() <= QD - 2);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!e_hit && mq[i].idx == rd_idx) begin
                e_hit  = 1'b1;
                e_data = mq[i].data;
            end
        end
        if (!e_hit && m_wr_en && m_wr_idx == rd_idx) begin
            e_hit  = 1'b1;
            e_data = m_wr_data;
        end
        check({tag, ".wr_en"}, 32'(wr_en), 32'(m_wr_en));
        if (m_wr_en) begin
            check({tag, ".wr_idx"}, 32'(wr_idx), 32'(m_wr_idx));
            check({tag, ".wr_data"}, 32'(wr_data), 32'(m_wr_data));
        end
        if (wr_en === 1'b1) wlog.push_back('{idx: wr_idx, data: wr_data});
        check({tag, ".up0_ready"}, 32'(up0_ready), 32'(e_rdy));
        check({tag, ".up1_ready"}, 32'(up1_ready), 32'(e_rdy));
        check({tag, ".init_done"}, 32'(init_done), 32'd1);
        check({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(e_hit));
        if (e_hit) check({tag, ".fwd_data"}, 32'(fwd_data), 32'(e_data));
`ifdef PHT_UPD_STATS_EN
        check({tag, ".stat_coalesce"}, stat_coalesce, m_coal);
        check({tag, ".stat_stall"}, stat_stall, m_stall);
`else
        check({tag, ".stat_coalesce"}, stat_coalesce, 32'd0);
        check({tag, ".stat_stall"}, stat_stall, 32'd0);
`endif
    endtask

    task automatic run_cycle(input string tag);
        model_step();
        next_cycle();
        compare_all(tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        up0_valid = 1'b1;
        up1_valid = 1'b1;
        next_cycle();
        next_cycle();
        check("reset.wr_en", 32'(wr_en), 32'd0);
        check("reset.init_done", 32'(init_done), 32'd0);
        check("reset.up0_ready", 32'(up0_ready), 32'd0);
        check("reset.up1_ready", 32'(up1_ready), 32'd0);
        check("reset.fwd_hit", 32'(fwd_hit), 32'd0);
        check("reset.stat_coalesce", stat_coalesce, 32'd0);
        check("reset.stat_stall", stat_stall, 32'd0);
        reset     = 1'b0;
        up0_valid = 1'b0;
        up1_valid = 1'b0;
    endtask

    // Full sweep: write i visible in sweep cycle i, init_done and readies only in the last.
    task automatic sweep_check(input string tag);
        int bad_en = 0, bad_wr = 0, bad_done = 0, bad_rdy = 0;
        for (int i = 0; i < TD; i++) begin
            up0_valid = 1'b1;
            up0_idx   = 11'($urandom);
            up1_valid = 1'($urandom);
            up1_idx   = 11'($urandom);
            next_cycle();
            if (wr_en !== 1'b1) bad_en++;
            if (wr_idx !== 11'(i) || wr_data !== 2'b01) bad_wr++;
            if (init_done !== (i == TD - 1)) bad_done++;
            if (up0_ready !== (i == TD - 1) || up1_ready !== (i == TD - 1)) bad_rdy++;
            if (i == 100) begin
                rd_idx = 11'($urandom);
                #1;
                check({tag, ".init_fwd_hit"}, 32'(fwd_hit), 32'd1);
                check({tag, ".init_fwd_data"}, 32'(fwd_data), 32'd1);
            end
        end
        up0_valid = 1'b0;
        up1_valid = 1'b0;
        check({tag, ".bad_wr_en_cycles"}, bad_en, 0);
        check({tag, ".bad_wr_addr_cycles"}, bad_wr, 0);
        check({tag, ".bad_init_done_cycles"}, bad_done, 0);
        check({tag, ".bad_ready_cycles"}, bad_rdy, 0);
        check({tag, ".stat_stall"}, stat_stall, 32'd0);
        model_reset();
    endtask

    initial begin
        int n40;
        logic [1:0] d40;
        logic [10:0] pool_base;

        reset     = 1'b1;
        up0_valid = 1'b0;
        up1_valid = 1'b0;
        up0_idx   = '0;
        up1_idx   = '0;
        up0_data  = '0;
        up1_data  = '0;
        rd_idx    = '0;

        do_reset();
        sweep_check("sweep0");

        // Single update: accept, write one cycle later, then idle.
        up0_valid = 1'b1; up0_idx = 11'h123; up0_data = 2'b11; rd_idx = 11'h123;
        run_cycle("single.acc");
        check("single.fwd_queued", 32'(fwd_hit), 32'd1);
        up0_valid = 1'b0;
        run_cycle("single.wr");
        check("single.wr_en", 32'(wr_en), 32'd1);
        check("single.wr_idx", 32'(wr_idx), 32'h123);
        check("single.wr_data", 32'(wr_data), 32'd3);
        run_cycle("single.idle");
        check("single.idle_wr_en", 32'(wr_en), 32'd0);

        // Same-cycle same index: one write, younger data wins.
        wlog.delete();
        up0_valid = 1'b1; up0_idx = 11'h040; up0_data = 2'b00;
        up1_valid = 1'b1; up1_idx = 11'h040; up1_data = 2'b10;
        run_cycle("same.acc");
        up0_valid = 1'b0; up1_valid = 1'b0;
        repeat (3) run_cycle("same.drain");
        n40 = 0; d40 = 2'bxx;
        foreach (wlog[i]) if (wlog[i].idx == 11'h040) begin n40++; d40 = wlog[i].data; end
        check("same.write_count", n40, 1);
        check("same.write_data", 32'(d40), 32'd2);
`ifdef PHT_UPD_STATS_EN
        check("same.stat_coalesce", stat_coalesce, 32'd1);
`endif

        // Backpressure burst: six distinct updates, one stalled cycle, in-order writes.
        wlog.delete();
        up0_valid = 1'b1; up1_valid = 1'b1;
        up0_idx = 11'h010; up0_data = 2'd0; up1_idx = 11'h011; up1_data = 2'd1;
        run_cycle("bp.a");
        check("bp.ready_after_a", 32'(up0_ready), 32'd1);
        up0_idx = 11'h012; up0_data = 2'd2; up1_idx = 11'h013; up1_data = 2'd3;
        run_cycle("bp.b");
        check("bp.ready_after_b", 32'(up0_ready), 32'd0);
        up0_idx = 11'h014; up0_data = 2'd0; up1_idx = 11'h015; up1_data = 2'd1;
        run_cycle("bp.stall");
        run_cycle("bp.d");
        up0_valid = 1'b0; up1_valid = 1'b0;
        repeat (6) run_cycle("bp.drain");
        check("bp.write_count", wlog.size(), 6);
        for (int i = 0; i < 6 && i < wlog.size(); i++) begin
            check($sformatf("bp.order%0d", i), 32'(wlog[i].idx), 32'h010 + 32'(i));
            check($sformatf("bp.data%0d", i), 32'(wlog[i].data), 32'(i % 4));
        end
`ifdef PHT_UPD_STATS_EN
        check("bp.stat_stall", stat_stall, 32'd1);
`endif

        // Forwarding at the last index, and a neighbouring miss.
        up0_valid = 1'b1; up0_idx = 11'h7FF; up0_data = 2'b11; rd_idx = 11'h7FF;
        run_cycle("fwd.acc");
        up0_valid = 1'b0;
        check("fwd.hit", 32'(fwd_hit), 32'd1);
        check("fwd.data", 32'(fwd_data), 32'd3);
        rd_idx = 11'h7FE;
        #1;
        check("fwd.miss", 32'(fwd_hit), 32'd0);
        repeat (3) run_cycle("fwd.drain");

        // Random traffic over a small index pool to force coalescing and stalls.
        pool_base = 11'h020;
        repeat (400) begin
            up0_valid = 1'($urandom);
            up1_valid = 1'($urandom);
            up0_idx   = pool_base + 11'($urandom_range(0, 7));
            up1_idx   = pool_base + 11'($urandom_range(0, 7));
            up0_data  = 2'($urandom);
            up1_data  = 2'($urandom);
            rd_idx    = pool_base + 11'($urandom_range(0, 7));
            run_cycle("rand");
        end
        up0_valid = 1'b0; up1_valid = 1'b0;
        repeat (8) run_cycle("rand.drain");
        check("rand.model_empty", mq.size(), 0);

        // Reset partway through a sweep restarts it from index 0.
        do_reset();
        repeat (500) next_cycle();
        check("midreset.ptr_wr_idx", 32'(wr_idx), 32'd499);
        do_reset();
        sweep_check("sweep1");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
